arp_tx: RTL and testbench

//  GMII transmit side of the ARP engine: on a start pulse, serialises one complete

---
 rtl/arp_tx.sv | 133 +++++++++++++
 tb/tb_arp_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_tx.sv
// GMII transmitter for one Ethernet II / ARP frame (request or reply) per start pulse.
// Outputs decode the registered state and byte counter, so they clear as soon as reset asserts.
module arp_tx #(
    parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic        i_gmii_txc,
    input  logic        i_rst,
    input  logic        i_arp_tx_en,
    input  logic        i_arp_tx_type,
    input  logic [47:0] i_des_mac,
    input  logic [31:0] i_des_ip,
    output logic        o_gmii_tx_en,
    output logic [7:0]  o_gmii_txd,
    output logic        o_arp_tx_done,
    output logic        o_arp_tx_busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PREAMBLE, ST_ETH_HEAD, ST_ARP_DATA, ST_PAD, ST_FCS, ST_IFG
    } state_t;

    localparam logic [4:0] IFG_LAST = 5'(IFG_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic        type_q;
    logic [47:0] mac_q;
    logic [31:0] ip_q;
    logic [31:0] crc_q;
    logic [31:0] fcs;
    logic [7:0]  tx_byte;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [7:0] mac_byte(input logic [47:0] m, input logic [4:0] i);
        return m[47 - 8 * i -: 8];
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] p, input logic [4:0] i);
        return p[31 - 8 * i -: 8];
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (i_arp_tx_en)       state_d = ST_PREAMBLE;
            ST_PREAMBLE: if (cnt_q == 5'd7)     state_d = ST_ETH_HEAD;
            ST_ETH_HEAD: if (cnt_q == 5'd13)    state_d = ST_ARP_DATA;
            ST_ARP_DATA: if (cnt_q == 5'd27)    state_d = ST_PAD;
            ST_PAD:      if (cnt_q == 5'd17)    state_d = ST_FCS;
            ST_FCS:      if (cnt_q == 5'd3)     state_d = ST_IFG;
            ST_IFG:      if (cnt_q == IFG_LAST) state_d = ST_IDLE;
            default:                            state_d = ST_IDLE;
        endcase
    end

    assign fcs = ~crc_q;

    always_comb begin
        tx_byte = 8'h00;
        unique case (state_q)
            ST_PREAMBLE: tx_byte = (cnt_q == 5'd7) ? 8'hD5 : 8'h55;
            ST_ETH_HEAD: begin
                if (cnt_q < 5'd6)       tx_byte = type_q ? mac_byte(mac_q, cnt_q) : 8'hFF;
                else if (cnt_q < 5'd12) tx_byte = mac_byte(BOARD_MAC, cnt_q - 5'd6);
                else if (cnt_q == 5'd12) tx_byte = 8'h08;
                else                     tx_byte = 8'h06;
            end
            ST_ARP_DATA: begin
                if (cnt_q < 5'd8) begin
                    case (cnt_q)
                        5'd1:    tx_byte = 8'h01;
                        5'd2:    tx_byte = 8'h08;
                        5'd4:    tx_byte = 8'h06;
                        5'd5:    tx_byte = 8'h04;
                        5'd7:    tx_byte = type_q ? 8'h02 : 8'h01;
                        default: tx_byte = 8'h00;
                    endcase
                end else if (cnt_q < 5'd14) begin
                    tx_byte = mac_byte(BOARD_MAC, cnt_q - 5'd8);
                end else if (cnt_q < 5'd18) begin
                    tx_byte = ip_byte(BOARD_IP, cnt_q - 5'd14);
                end else if (cnt_q < 5'd24) begin
                    tx_byte = type_q ? mac_byte(mac_q, cnt_q - 5'd18) : 8'h00;
                end else begin
                    tx_byte = ip_byte(ip_q, cnt_q - 5'd24);
                end
            end
            // FCS goes out least significant byte first
            ST_FCS:  tx_byte = fcs[8 * cnt_q[1:0] +: 8];
            default: tx_byte = 8'h00;
        endcase
    end

    always_ff @(posedge i_gmii_txc or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            type_q  <= 1'b0;
            mac_q   <= 48'h0;
            ip_q    <= 32'h0;
            crc_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q || state_q == ST_IDLE) ? 5'd0 : cnt_q + 5'd1;
            if (state_q == ST_IDLE && i_arp_tx_en) begin
                type_q <= i_arp_tx_type;
                mac_q  <= i_des_mac;
                ip_q   <= i_des_ip;
            end
            case (state_q)
                ST_PREAMBLE:                  crc_q <= 32'hFFFF_FFFF;
                ST_ETH_HEAD, ST_ARP_DATA, ST_PAD: crc_q <= crc32_byte(crc_q, tx_byte);
                default:                      crc_q <= crc_q;
            endcase
        end
    end

    assign o_gmii_tx_en  = (state_q != ST_IDLE) && (state_q != ST_IFG);
    assign o_gmii_txd    = tx_byte;
    assign o_arp_tx_done = (state_q == ST_IFG) && (cnt_q == 5'd0);
    assign o_arp_tx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_arp_tx.sv
// Directed bench for arp_tx: byte table checks, CRC model and residue, start filtering, reset.
module tb_arp_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        typ;
    logic [47:0] mac;
    logic [31:0] ip;
    logic        tx_en;
    logic [7:0]  txd;
    logic        done;
    logic        busy;

    int tests = 0;
    int fails = 0;

    typedef logic [7:0] frame_t [72];
    typedef struct {
        bit         t;
        int         idx;
        logic [7:0] exp;
    } vec_t;

    localparam logic [47:0] PEER_MAC = 48'hA0B1C2D3E4F5;
    localparam logic [31:0] PEER_IP  = 32'hC0A80166;

    arp_tx dut (
        .i_gmii_txc    (clk),
        .i_rst         (rst),
        .i_arp_tx_en   (en),
        .i_arp_tx_type (typ),
        .i_des_mac     (mac),
        .i_des_ip      (ip),
        .o_gmii_tx_en  (tx_en),
        .o_gmii_txd    (txd),
        .o_arp_tx_done (done),
        .o_arp_tx_busy (busy)
    );

    always #4 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit-serial LFSR, one data bit at a time, LSB first
    function automatic logic [31:0] crc_bits(input logic [31:0] c, input logic [7:0] d);
        logic fb;
        for (int i = 0; i < 8; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    function automatic frame_t build(input bit t, input logic [47:0] m, input logic [31:0] p);
        frame_t      f;
        logic [47:0] bm;
        logic [31:0] bip;
        logic [31:0] c;
        logic [7:0]  hdr [8];
        bm  = 48'h001122334455;
        bip = 32'hC0A8010A;
        hdr = '{8'h08, 8'h06, 8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04};
        for (int i = 0; i < 7; i++) f[i] = 8'h55;
        f[7] = 8'hD5;
        for (int i = 0; i < 6; i++) begin
            f[8 + i]  = t ? m[47 - 8 * i -: 8] : 8'hFF;
            f[14 + i] = bm[47 - 8 * i -: 8];
            f[30 + i] = bm[47 - 8 * i -: 8];
            f[40 + i] = t ? m[47 - 8 * i -: 8] : 8'h00;
        end
        for (int i = 0; i < 8; i++) f[20 + i] = hdr[i];
        f[28] = 8'h00;
        f[29] = t ? 8'h02 : 8'h01;
        for (int i = 0; i < 4; i++) begin
            f[36 + i] = bip[31 - 8 * i -: 8];
            f[46 + i] = p[31 - 8 * i -: 8];
        end
        for (int i = 50; i < 68; i++) f[i] = 8'h00;
        c = 32'hFFFF_FFFF;
        for (int i = 8; i < 68; i++) c = crc_bits(c, f[i]);
        c = ~c;
        for (int i = 0; i < 4; i++) f[68 + i] = c[8 * i +: 8];
        return f;
    endfunction

    // One start pulse, then scramble the inputs so only latched values can reach the frame
    task automatic run_frame(input bit t, input logic [47:0] m, input logic [31:0] p,
                             output frame_t f, output int n, output int done_k,
                             output int done_n);
        n = 0;
        done_k = -1;
        done_n = 0;
        for (int i = 0; i < 72; i++) f[i] = 8'hXX;
        @(negedge clk);
        typ = t; mac = m; ip = p; en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0; typ = !t; mac = ~m; ip = ~p;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            if (tx_en) begin
                if (n < 72) f[n] = txd;
                n++;
            end
            if (done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) check({name, "_idle_timeout"}, 1, 0);
    endtask

    function automatic int diff_count(input frame_t a, input frame_t b);
        int d;
        d = 0;
        for (int i = 0; i < 72; i++) if (a[i] !== b[i]) d++;
        return d;
    endfunction

    initial begin
        frame_t      rep, req, exp_f, got;
        vec_t        vecs[$];
        int          n, dk, dn;
        logic [31:0] res;
        int          rises, f1_bytes, ifg_cnt, idle_cnt;
        logic        prev_en;

        vecs.push_back('{1'b1, 0, 8'h55});  vecs.push_back('{1'b1, 7, 8'hD5});
        vecs.push_back('{1'b1, 8, 8'hA0});  vecs.push_back('{1'b1, 13, 8'hF5});
        vecs.push_back('{1'b1, 14, 8'h00}); vecs.push_back('{1'b1, 19, 8'h55});
        vecs.push_back('{1'b1, 20, 8'h08}); vecs.push_back('{1'b1, 21, 8'h06});
        vecs.push_back('{1'b1, 27, 8'h04}); vecs.push_back('{1'b1, 28, 8'h00});
        vecs.push_back('{1'b1, 29, 8'h02}); vecs.push_back('{1'b1, 36, 8'hC0});
        vecs.push_back('{1'b1, 39, 8'h0A}); vecs.push_back('{1'b1, 40, 8'hA0});
        vecs.push_back('{1'b1, 45, 8'hF5}); vecs.push_back('{1'b1, 46, 8'hC0});
        vecs.push_back('{1'b1, 47, 8'hA8}); vecs.push_back('{1'b1, 48, 8'h01});
        vecs.push_back('{1'b1, 49, 8'h66}); vecs.push_back('{1'b1, 67, 8'h00});
        vecs.push_back('{1'b0, 8, 8'hFF});  vecs.push_back('{1'b0, 13, 8'hFF});
        vecs.push_back('{1'b0, 29, 8'h01}); vecs.push_back('{1'b0, 35, 8'h55});
        vecs.push_back('{1'b0, 40, 8'h00}); vecs.push_back('{1'b0, 45, 8'h00});
        vecs.push_back('{1'b0, 46, 8'hC0}); vecs.push_back('{1'b0, 49, 8'h66});

        rst = 1'b1; en = 1'b0; typ = 1'b0; mac = '0; ip = '0;
        #10;
        check("reset_tx_en", tx_en, 0);
        check("reset_txd", txd, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reply
        run_frame(1'b1, PEER_MAC, PEER_IP, rep, n, dk, dn);
        check("reply_len", n, 72);
        check("reply_done_cycle", dk, 73);
        check("reply_done_pulses", dn, 1);
        exp_f = build(1'b1, PEER_MAC, PEER_IP);
        check("reply_frame_model_diffs", diff_count(rep, exp_f), 0);
        res = 32'hFFFF_FFFF;
        for (int i = 8; i < 72; i++) res = crc_bits(res, rep[i]);
        check("reply_crc_residue", res, 32'hDEBB20E3);
        wait_idle("reply");

        // Request
        run_frame(1'b0, PEER_MAC, PEER_IP, req, n, dk, dn);
        check("request_len", n, 72);
        check("request_done_cycle", dk, 73);
        exp_f = build(1'b0, PEER_MAC, PEER_IP);
        check("request_frame_model_diffs", diff_count(req, exp_f), 0);
        res = 32'hFFFF_FFFF;
        for (int i = 8; i < 72; i++) res = crc_bits(res, req[i]);
        check("request_crc_residue", res, 32'hDEBB20E3);
        wait_idle("request");

        for (int i = 0; i < vecs.size(); i++) begin
            check($sformatf("byte%0d_type%0d", vecs[i].idx, vecs[i].t),
                  vecs[i].t ? rep[vecs[i].idx] : req[vecs[i].idx], vecs[i].exp);
        end

        // Start held high through frame and IFG; only the first idle cycle may restart
        @(negedge clk);
        typ = 1'b1; mac = PEER_MAC; ip = PEER_IP; en = 1'b1;
        rises = 0; f1_bytes = 0; ifg_cnt = 0; idle_cnt = 0; prev_en = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_en && !prev_en) rises++;
            if (rises == 1 && tx_en) f1_bytes++;
            if (rises == 1 && !tx_en && busy) ifg_cnt++;
            if (rises == 1 && !busy) idle_cnt++;
            if (rises >= 2) en = 1'b0;
            prev_en = tx_en;
        end
        en = 1'b0;
        check("held_start_frames", rises, 2);
        check("held_start_frame1_len", f1_bytes, 72);
        check("held_start_ifg_cycles", ifg_cnt, 12);
        check("held_start_idle_gap", idle_cnt, 1);
        wait_idle("held");
        repeat (2) @(negedge clk);

        // Asynchronous reset while byte 30 is on the wire
        @(negedge clk);
        typ = 1'b1; mac = PEER_MAC; ip = PEER_IP; en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (31) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        check("midframe_reset_tx_en", tx_en, 0);
        check("midframe_reset_txd", txd, 0);
        check("midframe_reset_busy", busy, 0);
        check("midframe_reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_idle_tx_en", tx_en, 0);

        run_frame(1'b1, 48'h0123456789AB, 32'h0A000001, got, n, dk, dn);
        check("post_reset_len", n, 72);
        check("post_reset_done_cycle", dk, 73);
        exp_f = build(1'b1, 48'h0123456789AB, 32'h0A000001);
        check("post_reset_frame_model_diffs", diff_count(got, exp_f), 0);
        check("post_reset_byte8", got[8], 8'h01);
        check("post_reset_byte49", got[49], 8'h01);
        wait_idle("post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
